// File: rtl/cpu_timing_pkg.sv
// Shared types and timing helpers for the 6502 bus timing generator.
// Cycle lengths are counted in 64 MHz system clocks.
package cpu_timing_pkg;

  localparam int SYS_CLOCK_MHZ = 64;
  localparam int TADS_NS_DFLT  = 40;
  localparam int TDSU_NS_DFLT  = 32;

  typedef enum logic [1:0] {
    SPEED_1M     = 2'b00,
    SPEED_2M     = 2'b01,
    SPEED_4M     = 2'b10,
    SPEED_1M_ALT = 2'b11
  } cpu_speed_t;

  typedef enum logic [1:0] {
    CYC_IDLE = 2'd0,
    CYC_CPU  = 2'd1,
    CYC_DMA  = 2'd2
  } bus_cycle_t;

  // Registered output bundle, one bit per strobe/level.
  typedef struct packed {
    logic phi2;
    logic be;
    logic addr_stb;
    logic data_stb;
    logic grant;
    logic dma_stb;
    logic cyc_start;
  } bus_out_t;

  typedef struct packed {
    logic [5:0] last;
    logic [5:0] half;
    logic [5:0] dstb;
  } cyc_const_t;

  // Round to the nearest system clock.
  function automatic int ns_to_cycles(input int ns);
    return (ns * SYS_CLOCK_MHZ + 500) / 1000;
  endfunction

  function automatic cyc_const_t cyc_consts(input cpu_speed_t s, input logic [5:0] margin);
    cyc_const_t c;
    case (s)
      SPEED_2M: begin c.last = 6'd31; c.half = 6'd16; end
      SPEED_4M: begin c.last = 6'd15; c.half = 6'd8;  end
      default:  begin c.last = 6'd63; c.half = 6'd32; end
    endcase
    c.dstb = c.last - margin;
    return c;
  endfunction

endpackage

// File: rtl/cpu_timing_if.sv
// Bus-side signals of the timing generator: CPU/DMA controls in, strobes out.
interface cpu_timing_if;
  logic [1:0] cpu_speed_i;
  logic       cpu_en_i;
  logic       dma_req_i;
  logic       dma_grant_o;
  logic       dma_strobe_o;
  logic       cpu_phi2_o;
  logic       cpu_be_o;
  logic       cpu_addr_strobe_o;
  logic       cpu_data_strobe_o;
  logic       cycle_start_o;

  modport master (
    input  cpu_speed_i, cpu_en_i, dma_req_i,
    output dma_grant_o, dma_strobe_o, cpu_phi2_o, cpu_be_o,
           cpu_addr_strobe_o, cpu_data_strobe_o, cycle_start_o
  );

  modport slave (
    output cpu_speed_i, cpu_en_i, dma_req_i,
    input  dma_grant_o, dma_strobe_o, cpu_phi2_o, cpu_be_o,
           cpu_addr_strobe_o, cpu_data_strobe_o, cycle_start_o
  );
endinterface

// File: rtl/cpu_timing.sv
// phi2 / bus-enable / strobe generator; DMA cycles replace CPU cycles by
// holding phi2 low for a whole bus cycle (stretched phi1).
module cpu_timing
  import cpu_timing_pkg::*;
#(
  parameter int TADS_NS = TADS_NS_DFLT,
  parameter int TDSU_NS = TDSU_NS_DFLT
) (
  input  logic         sys_clock_i,
  input  logic         sys_reset_ni,
  cpu_timing_if.master bus
);

  localparam int ADDR_CNT = ns_to_cycles(TADS_NS);
  localparam int DSU_CNT  = ns_to_cycles(TDSU_NS);
  localparam logic [5:0] ADDR_POS = 6'(ADDR_CNT);
  localparam logic [5:0] DSU_POS  = 6'(DSU_CNT);

  // Strobes must straddle the phi2 rising edge at the fastest speed (N=16).
  if ((15 - DSU_CNT) <= 8) begin : g_bad_data_strobe
    $error("cpu_timing: data strobe not in phi2-high half at N=16");
  end
  if (ADDR_CNT >= 8) begin : g_bad_addr_strobe
    $error("cpu_timing: address strobe not in phi1 half at N=16");
  end

  logic [5:0] count_q, count_d;
  bus_cycle_t state_q, state_d;
  cpu_speed_t speed_q, speed_d;
  bus_out_t   out_q, out_d;
  cyc_const_t cur, nxt;

  always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      count_q <= '0;
      state_q <= CYC_IDLE;
      speed_q <= SPEED_1M;
      out_q   <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      speed_q <= speed_d;
      out_q   <= out_d;
    end
  end

  // Outputs are decoded from the next count/state so the registered
  // strobes line up with count_q.
  always_comb begin
    cur     = cyc_consts(speed_q, DSU_POS);
    count_d = count_q + 6'd1;
    state_d = state_q;
    speed_d = speed_q;
    if (count_q == cur.last) begin
      count_d = '0;
      speed_d = cpu_speed_t'(bus.cpu_speed_i);
      if (bus.dma_req_i)     state_d = CYC_DMA;
      else if (bus.cpu_en_i) state_d = CYC_CPU;
      else                   state_d = CYC_IDLE;
    end

    nxt             = cyc_consts(speed_d, DSU_POS);
    out_d           = '0;
    out_d.cyc_start = (count_d == 6'd0);
    case (state_d)
      CYC_CPU: begin
        out_d.be       = 1'b1;
        out_d.phi2     = (count_d >= nxt.half);
        out_d.addr_stb = (count_d == ADDR_POS);
        out_d.data_stb = (count_d == nxt.dstb);
      end
      CYC_DMA: begin
        out_d.grant    = 1'b1;
        out_d.dma_stb  = (count_d == nxt.dstb);
      end
      default: begin
        out_d.be       = 1'b1;
      end
    endcase
  end

  assign bus.cpu_phi2_o        = out_q.phi2;
  assign bus.cpu_be_o          = out_q.be;
  assign bus.cpu_addr_strobe_o = out_q.addr_stb;
  assign bus.cpu_data_strobe_o = out_q.data_stb;
  assign bus.dma_grant_o       = out_q.grant;
  assign bus.dma_strobe_o      = out_q.dma_stb;
  assign bus.cycle_start_o     = out_q.cyc_start;

endmodule
